// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: four-digit BCD up/down counter with an internal tick
// prescaler. It drives the hex display driver (hexs/les/points) and a wrap
// LED (rc). Everything runs in the single clk domain.
module bcd_tick_counter #(
  parameter int DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] hexs,
  output logic [3:0]  les,
  output logic [3:0]  points,
  output logic        tick,
  output logic        rc
);

  localparam int            PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          hb_q, hb_d;
  logic          tick_q, tick_d;
  logic          rc_q, rc_d;
  logic [16:0]   step_res;

  // Force every digit of a loaded value into 0..9 so the count stays BCD.
  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Add or subtract one in BCD with ripple carry/borrow across the digits.
  // Bit 16 of the result is set when the carry/borrow leaves digit3,
  // i.e. on 9999->0000 going up or 0000->9999 going down.
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic dir);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[i*4 +: 4];
      if (c) begin
        if (dir) begin
          if (d == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
            c = 1'b1;
          end else begin
            r[i*4 +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[i*4 +: 4] = 4'd9;
            c = 1'b1;
          end else begin
            r[i*4 +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  assign step_res = bcd_step(cnt_q, up);

  // Next-state: clr beats load beats the prescaler-driven step.
  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    hb_d   = hb_q;
    tick_d = 1'b0;
    rc_d   = 1'b0;
    if (clr) begin
      pcnt_d = '0;
      cnt_d  = 16'h0000;
    end else if (load) begin
      pcnt_d = '0;
      cnt_d  = bcd_clamp(load_val);
    end else if (en) begin
      if (pcnt_q == PMAX) begin
        pcnt_d = '0;
        cnt_d  = step_res[15:0];
        hb_d   = ~hb_q;
        tick_d = 1'b1;
        rc_d   = step_res[16];
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
      cnt_q  <= 16'h0000;
      hb_q   <= 1'b0;
      tick_q <= 1'b0;
      rc_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      hb_q   <= hb_d;
      tick_q <= tick_d;
      rc_q   <= rc_d;
    end
  end

  // Leading-zero blanking; digit0 always shows so zero reads as "0".
  always_comb begin
    les    = 4'b0000;
    les[3] = (cnt_q[15:12] == 4'd0);
    les[2] = les[3] & (cnt_q[11:8] == 4'd0);
    les[1] = les[2] & (cnt_q[7:4] == 4'd0);
  end

  assign hexs   = cnt_q;
  assign points = {3'b000, hb_q};
  assign tick   = tick_q;
  assign rc     = rc_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter with DIV=4.
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] hexs;
  logic [3:0]  les;
  logic [3:0]  points;
  logic        tick;
  logic        rc;

  int total = 0;
  int bad = 0;

  bcd_tick_counter #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .hexs(hexs), .les(les), .points(points),
    .tick(tick), .rc(rc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held across edges
    edges(2);
    chk("rst_hexs", hexs, 16'h0000);
    chk("rst_les", {12'h0, les}, 16'h000E);
    chk("rst_points", {12'h0, points}, 16'h0000);
    chk("rst_tick", {15'h0, tick}, 16'h0000);
    chk("rst_rc", {15'h0, rc}, 16'h0000);

    // Count up, period 4
    rst = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edges(1);
      chk("p1_tick_low", {15'h0, tick}, 16'h0000);
    end
    edges(1);
    chk("p1_tick", {15'h0, tick}, 16'h0001);
    chk("p1_hexs", hexs, 16'h0001);
    chk("p1_les", {12'h0, les}, 16'h000E);
    chk("p1_points", {12'h0, points}, 16'h0001);
    edges(1);
    chk("p1_tick_one_cycle", {15'h0, tick}, 16'h0000);
    edges(3);
    chk("p2_tick", {15'h0, tick}, 16'h0001);
    chk("p2_hexs", hexs, 16'h0002);
    chk("p2_points", {12'h0, points}, 16'h0000);

    // Load 9998, up-wrap
    load = 1'b1; load_val = 16'h9998;
    edges(1);
    load = 1'b0;
    chk("ld9998_hexs", hexs, 16'h9998);
    chk("ld9998_tick", {15'h0, tick}, 16'h0000);
    edges(4);
    chk("up9999_hexs", hexs, 16'h9999);
    chk("up9999_les", {12'h0, les}, 16'h0000);
    chk("up9999_rc", {15'h0, rc}, 16'h0000);
    edges(3);
    chk("pre_wrap_rc", {15'h0, rc}, 16'h0000);
    edges(1);
    chk("upwrap_hexs", hexs, 16'h0000);
    chk("upwrap_rc", {15'h0, rc}, 16'h0001);
    chk("upwrap_les", {12'h0, les}, 16'h000E);
    edges(1);
    chk("upwrap_rc_one_cycle", {15'h0, rc}, 16'h0000);

    // Down-wrap; prescaler already one edge into its period
    up = 1'b0;
    edges(3);
    chk("dnwrap_hexs", hexs, 16'h9999);
    chk("dnwrap_rc", {15'h0, rc}, 16'h0001);
    chk("dnwrap_tick", {15'h0, tick}, 16'h0001);
    edges(4);
    chk("dn9998_hexs", hexs, 16'h9998);
    chk("dn9998_rc", {15'h0, rc}, 16'h0000);

    // Load 0100, borrow across digits
    load = 1'b1; load_val = 16'h0100;
    edges(1);
    load = 1'b0;
    chk("ld0100_hexs", hexs, 16'h0100);
    chk("ld0100_les", {12'h0, les}, 16'h0008);
    edges(4);
    chk("dn0099_hexs", hexs, 16'h0099);
    chk("dn0099_les", {12'h0, les}, 16'h000C);
    chk("dn0099_rc", {15'h0, rc}, 16'h0000);

    // Clamped load, then enable gap of 3 cycles
    load = 1'b1; load_val = 16'h0A5F;
    edges(1);
    load = 1'b0; up = 1'b1;
    chk("clamp_hexs", hexs, 16'h0959);
    chk("clamp_les", {12'h0, les}, 16'h0008);
    edges(2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk("en_off_tick", {15'h0, tick}, 16'h0000);
      chk("en_off_hexs", hexs, 16'h0959);
    end
    en = 1'b1;
    edges(1);
    chk("en_gap_early", {15'h0, tick}, 16'h0000);
    edges(1);
    chk("en_gap_tick", {15'h0, tick}, 16'h0001);
    chk("en_gap_hexs", hexs, 16'h0960);

    // clr on the wrap edge
    edges(3);
    chk("pre_clr_tick", {15'h0, tick}, 16'h0000);
    clr = 1'b1;
    edges(1);
    clr = 1'b0;
    chk("clr_hexs", hexs, 16'h0000);
    chk("clr_tick", {15'h0, tick}, 16'h0000);
    chk("clr_rc", {15'h0, rc}, 16'h0000);
    edges(3);
    chk("post_clr_early", {15'h0, tick}, 16'h0000);
    edges(1);
    chk("post_clr_tick", {15'h0, tick}, 16'h0001);
    chk("post_clr_hexs", hexs, 16'h0001);
    chk("post_clr_points", {12'h0, points}, 16'h0001);

    // Asynchronous reset mid-period at 0123
    load = 1'b1; load_val = 16'h0123;
    edges(1);
    load = 1'b0;
    chk("ld0123_hexs", hexs, 16'h0123);
    edges(2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_hexs", hexs, 16'h0000);
    chk("arst_les", {12'h0, les}, 16'h000E);
    chk("arst_points", {12'h0, points}, 16'h0000);
    chk("arst_tick", {15'h0, tick}, 16'h0000);
    edges(1);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edges(1);
      chk("resume_tick_low", {15'h0, tick}, 16'h0000);
    end
    edges(1);
    chk("resume_tick", {15'h0, tick}, 16'h0001);
    chk("resume_hexs", hexs, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Four-digit BCD up/down counter with a built-in tick prescaler. It replaces the separate 1 s clock divider plus 4-bit counter pair as the stage directly upstream of the hex display driver. Its `hexs`, `les` and `points` outputs connect straight to the display driver's inputs of the same names, and `rc` drives a board LED. All logic runs in the single `clk` domain; no derived clocks.

## Interface
- `DIV`, default 100_000_000: prescaler period in `clk` cycles (1 s at 100 MHz). Legal range is ≥2; benches use 4.
- `clk`  in  1  system clock, all registers on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  count enable; 0 freezes the prescaler and the count
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `clr`  in  1  synchronous clear of count and prescaler
- `load`  in  1  synchronous load of `load_val`
- `load_val`  in  16  four BCD digits, [15:12] = digit3 (most significant)
- `hexs`  out  16  current count, four BCD digits, to the display
- `les`  out  4  per-digit blank mask (1 = blank) with leading-zero suppression
- `points`  out  4  decimal points; bit0 = heartbeat, bits[3:1] = 0
- `tick`  out  1  one-cycle pulse per prescaler period
- `rc`  out  1  one-cycle wrap pulse

## Operation
- Prescaler `pcnt` counts 0..DIV-1 while `en`=1 and holds while `en`=0. At DIV-1 with `en`=1, it returns to 0 and a step occurs.
- The step priority per edge is `clr` > `load` > tick step.
  - `clr` sets the count to 0000 and `pcnt` to 0. There is no tick, no rc and no heartbeat change.
  - `load` sets the count to `load_val` and `pcnt` to 0. Any digit >9 is clamped to 9. There is no tick and no rc.
  - A tick step applies count ± 1 in BCD with ripple carry or borrow across digits, and toggles the heartbeat bit.
- Wrap behaviour:
  - Up: 9999 → 0000 sets `rc`.
  - Down: 0000 → 9999 sets `rc`.
  - No other step sets `rc`.
- `up` is sampled on the step edge. A direction change takes effect at the next tick; the prescaler is not disturbed.
- `les` is combinational from the count register:
  - les[3] = (d3==0)
  - les[2] = les[3] & (d2==0)
  - les[1] = les[2] & (d1==0)
  - les[0] = 0, so digit0 is never blanked.
- `points` = {3'b000, hb}.
- The count never holds a non-BCD digit.

## Timing
- Reset (asynchronous, while `rst`=0), all outputs valid without a clock edge:
  - `pcnt`=0, count=0000, hb=0, `tick`=0, `rc`=0.
  - This gives `hexs`=16'h0000, `les`=4'b1110, `points`=4'b0000.
- `tick`, `rc`, the count and hb are registered and updated on the same edge. `tick`/`rc` are high for exactly the one cycle in which the new count is first visible.
- Period: with `en` held at 1 from reset release, the first step happens on the DIV-th rising edge. Each later step follows DIV edges after the previous one.
- Latency:
  - `clr`/`load` are visible one edge after they are sampled.
  - After either, the next step comes DIV edges later, provided `en`=1.
- `en`=0 for N cycles delays the next step by exactly N cycles. `tick` and `rc` stay 0 while `en`=0.
- `clr` or `load` coincident with a prescaler wrap: the clear or load wins, and `tick`=0, `rc`=0 on the following cycle.
- Reset mid-period is asynchronous: all state returns to reset values immediately, and the period restarts from 0 after `rst` returns to 1.

## Test plan
- DIV=4, reset, `en`=1, `up`=1 → `tick` high for 1 cycle every 4 cycles; after 4 edges `hexs`=0001, `les`=1110, `points`=0001; after 8 edges `hexs`=0002, `points`=0000.
- Load 16'h9998, `up`=1 → next tick `hexs`=9999 with `les`=0000; following tick `hexs`=0000 with `rc`=1 for exactly one cycle and `les`=1110.
- From 0000 with `up`=0 → one tick gives `hexs`=9999 and `rc`=1; the next tick gives 9998 and `rc`=0. Load 16'h0100, then down one tick → 0099 with `les`=1100.
- Load 16'h0A5F → `hexs`=16'h0959 and `les`=1000. Drop `en` for 3 cycles mid-period → step delayed by exactly 3 cycles.
- Assert `clr` on the edge where `pcnt`=DIV-1 → `hexs`=0000, `tick`=0, `rc`=0; the next tick arrives 4 edges later.
- Assert `rst`=0 asynchronously between edges at count 0123 → `hexs`=0000, `les`=1110, `points`=0000, `tick`=0 before the next clock edge; counting resumes 4 edges after release.
